// File: rtl/ones_count_pkg.sv
// Shared definitions for the ones-count engine: FSM state encoding and a
// constant ceil(log2) helper used to size counters at elaboration.
package ones_count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/chunk_ones_counter.sv
// Combinational popcount of a W-bit chunk; result is clog2(W+1) bits wide.
module chunk_ones_counter
  import ones_count_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]          din,
  output logic [clog2(W+1)-1:0] count
);

  localparam int unsigned CW = clog2(W + 1);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < W; i++) begin
      count = count + CW'(din[i]);
    end
  end

endmodule

// File: rtl/ones_count_engine.sv
// Multi-cycle ones/zeros counter: accepts a word in IDLE, consumes CHUNK_W bits
// per clock in COUNT, then presents count and parity in DONE until consumed.
module ones_count_engine
  import ones_count_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CHUNK_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           In,
  input  logic                        mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [clog2(DATA_W+1)-1:0]  out,
  output logic                        parity
);

  localparam int unsigned CNT_W = clog2(DATA_W + 1);
  localparam int unsigned NCH   = DATA_W / CHUNK_W;
  localparam int unsigned CC_W  = clog2(NCH + 1);
  localparam int unsigned PC_W  = clog2(CHUNK_W + 1);

  if (CHUNK_W < 1 || CHUNK_W > DATA_W || (DATA_W % CHUNK_W) != 0) begin : g_param_check
    $fatal(1, "ones_count_engine: DATA_W (%0d) must be a nonzero multiple of CHUNK_W (%0d)",
           DATA_W, CHUNK_W);
  end

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic                par_acc_q, par_acc_d;
  logic [CC_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]    out_q, out_d;
  logic                parity_q, parity_d;

  logic [CHUNK_W-1:0]  chunk_raw;
  logic [CHUNK_W-1:0]  chunk_sel;
  logic [PC_W-1:0]     chunk_pc;
  logic [CNT_W-1:0]    acc_next;
  logic                par_next;
  logic                last_chunk;

  // Parity always follows the raw bits; only the count sees the mode inversion.
  always_comb begin
    chunk_raw  = shreg_q[CHUNK_W-1:0];
    chunk_sel  = mode_q ? ~chunk_raw : chunk_raw;
    acc_next   = acc_q + CNT_W'(chunk_pc);
    par_next   = par_acc_q ^ (^chunk_raw);
    last_chunk = (cnt_q == CC_W'(NCH - 1));
  end

  chunk_ones_counter #(
    .W (CHUNK_W)
  ) u_chunk (
    .din   (chunk_sel),
    .count (chunk_pc)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    par_acc_d = par_acc_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    parity_d  = parity_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d   = In;
          mode_d    = mode;
          acc_d     = '0;
          par_acc_d = 1'b0;
          cnt_d     = '0;
          state_d   = COUNT;
        end
      end
      COUNT: begin
        acc_d     = acc_next;
        par_acc_d = par_next;
        shreg_d   = shreg_q >> CHUNK_W;
        cnt_d     = cnt_q + CC_W'(1);
        // Result registers update only on the final chunk, so they keep the
        // previous result visible throughout IDLE and COUNT.
        if (last_chunk) begin
          out_d    = acc_next;
          parity_d = par_next;
          state_d  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out    = out_q;
    parity = parity_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      mode_q    <= 1'b0;
      acc_q     <= '0;
      par_acc_q <= 1'b0;
      cnt_q     <= '0;
      out_q     <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      par_acc_q <= par_acc_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      parity_q  <= parity_d;
    end
  end

endmodule
